// File: rtl/tone_pkg.sv
// Shared types and note constants for the tone sequencer.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MANUAL    = 2'd1,
    ST_AUTO_HOLD = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int NOTE_COUNT = 8;
  localparam int NOTE_IDX_W = 3;

  // C5 .. C6 in whole Hz; chosen so the truncated half-period matches the divider table.
  localparam int unsigned NOTE_HZ [NOTE_COUNT] = '{523, 587, 659, 698, 783, 880, 987, 1046};

endpackage

// File: rtl/tone_sequencer_note_lut.sv
// Combinational note index to divider half-period count lookup.
module note_lut
  import tone_pkg::*;
#(
  parameter int N      = 32,
  parameter int CLK_HZ = 50_000_000
) (
  input  logic [NOTE_IDX_W-1:0] idx,
  output logic [N-1:0]          count
);

  function automatic logic [N-1:0] half_period(input int unsigned f_hz);
    longint q;
    q = longint'(CLK_HZ) / (64'd2 * longint'(f_hz)) - 64'd1;
    return N'(q);
  endfunction

  // Evaluated at elaboration so no divider is built in hardware.
  localparam logic [N-1:0] COUNTS [NOTE_COUNT] = '{
    half_period(NOTE_HZ[0]), half_period(NOTE_HZ[1]),
    half_period(NOTE_HZ[2]), half_period(NOTE_HZ[3]),
    half_period(NOTE_HZ[4]), half_period(NOTE_HZ[5]),
    half_period(NOTE_HZ[6]), half_period(NOTE_HZ[7])
  };

  always_comb begin
    count = COUNTS[idx];
  end

endmodule

// File: rtl/tone_sequencer.sv
// Manual/auto note sequencer feeding a downstream clock divider.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int N          = 32,
  parameter int CLK_HZ     = 50_000_000,
  parameter int NOTE_TICKS = 25_000_000,
  parameter int LOOP       = 0
) (
  input  logic                  inclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [NOTE_IDX_W-1:0] note_sel,
  output logic [N-1:0]          div_clk_count,
  output logic                  tone_en,
  output logic [NOTE_IDX_W-1:0] note_idx,
  output logic                  update,
  output logic                  busy,
  output logic                  done
);

  localparam int TW = $clog2(NOTE_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(NOTE_TICKS - 1);
  localparam logic [NOTE_IDX_W-1:0] LAST_NOTE = NOTE_IDX_W'(NOTE_COUNT - 1);

  state_e                  state_q, state_d;
  logic [N-1:0]            div_q, div_d;
  logic [NOTE_IDX_W-1:0]   note_idx_q, note_idx_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic                    update_q, update_d;
  logic                    done_q, done_d;
  logic [NOTE_IDX_W-1:0]   lut_idx;
  logic [N-1:0]            lut_count;

  note_lut #(.N(N), .CLK_HZ(CLK_HZ)) u_note_lut (
    .idx   (lut_idx),
    .count (lut_count)
  );

  // Index whose count would be loaded on the next edge in the current state.
  always_comb begin
    lut_idx = note_sel;
    case (state_q)
      ST_IDLE:      lut_idx = mode ? '0 : note_sel;
      ST_AUTO_HOLD: lut_idx = note_idx_q + NOTE_IDX_W'(1);
      default:      lut_idx = note_sel;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    note_idx_d = note_idx_q;
    tick_d     = tick_q;
    update_d   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = mode ? ST_AUTO_HOLD : ST_MANUAL;
          note_idx_d = lut_idx;
          div_d      = lut_count;
          tick_d     = '0;
          update_d   = 1'b1;
        end
      end
      ST_MANUAL: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (note_sel != note_idx_q) begin
          note_idx_d = note_sel;
          div_d      = lut_count;
          update_d   = 1'b1;
        end
      end
      ST_AUTO_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (note_idx_q == LAST_NOTE && LOOP == 0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            note_idx_d = lut_idx;
            div_d      = lut_count;
            update_d   = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      note_idx_q <= '0;
      tick_q     <= '0;
      update_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      note_idx_q <= note_idx_d;
      tick_q     <= tick_d;
      update_q   <= update_d;
      done_q     <= done_d;
    end
  end

  assign div_clk_count = div_q;
  assign note_idx      = note_idx_q;
  assign update        = update_q;
  assign done          = done_q;
  assign busy          = (state_q != ST_IDLE);
  assign tone_en       = (state_q == ST_MANUAL) || (state_q == ST_AUTO_HOLD);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with one-shot and looping instances.
module tb_tone_sequencer;

  logic        inclk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        mode  = 1'b0;
  logic [2:0]  note_sel = 3'd0;

  logic [31:0] div_a, div_b;
  logic        ten_a, ten_b, upd_a, upd_b, busy_a, busy_b, done_a, done_b;
  logic [2:0]  idx_a, idx_b;

  int tests_run = 0;
  int tests_failed = 0;
  logic loop_done_seen = 1'b0;

  localparam int TABLE [8] = '{47800, 42588, 37935, 35815, 31927, 28408, 25328, 23899};

  tone_sequencer #(.N(32), .CLK_HZ(50_000_000), .NOTE_TICKS(4), .LOOP(0)) dut (
    .inclk(inclk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .note_sel(note_sel), .div_clk_count(div_a), .tone_en(ten_a), .note_idx(idx_a),
    .update(upd_a), .busy(busy_a), .done(done_a)
  );

  tone_sequencer #(.N(32), .CLK_HZ(50_000_000), .NOTE_TICKS(4), .LOOP(1)) dut_loop (
    .inclk(inclk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .note_sel(note_sel), .div_clk_count(div_b), .tone_en(ten_b), .note_idx(idx_b),
    .update(upd_b), .busy(busy_b), .done(done_b)
  );

  always #5 inclk = ~inclk;

  always @(negedge inclk) if (done_b) loop_done_seen <= 1'b1;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  initial begin
    int upd_count;

    // reset state
    repeat (2) step();
    check("rst_div", 32'(div_a), 0);
    check("rst_idx", 32'(idx_a), 0);
    check("rst_upd", 32'(upd_a), 0);
    check("rst_ten", 32'(ten_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    reset = 1'b1;
    step();

    // manual start on note 5
    start = 1'b1; mode = 1'b0; note_sel = 3'd5;
    step();
    start = 1'b0;
    check("man_div", 32'(div_a), 28408);
    check("man_idx", 32'(idx_a), 5);
    check("man_upd", 32'(upd_a), 1);
    check("man_ten", 32'(ten_a), 1);
    check("man_busy", 32'(busy_a), 1);
    step();
    check("man_upd_hold", 32'(upd_a), 0);

    // manual note change 5 -> 2, then hold
    note_sel = 3'd2;
    step();
    check("chg_div", 32'(div_a), 37935);
    check("chg_idx", 32'(idx_a), 2);
    check("chg_upd", 32'(upd_a), 1);
    upd_count = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (upd_a) upd_count++;
    end
    check("hold_no_upd", upd_count, 0);

    // stop from manual; count holds in idle
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("mstop_busy", 32'(busy_a), 0);
    check("mstop_ten", 32'(ten_a), 0);
    check("mstop_done", 32'(done_a), 0);
    check("mstop_div_hold", 32'(div_a), 37935);

    // start and stop together in idle
    start = 1'b1; stop = 1'b1; mode = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy_a), 0);
    check("ss_upd", 32'(upd_a), 0);

    // auto sequence on both instances
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    check("auto0_div", 32'(div_a), 47800);
    check("auto0_idx", 32'(idx_a), 0);
    check("auto0_upd", 32'(upd_a), 1);
    for (int k = 1; k < 32; k++) begin
      // start with a mode change while busy must be ignored
      start = (k == 10);
      mode  = (k == 10) ? 1'b0 : 1'b1;
      step();
      check($sformatf("auto_idx_%0d", k), 32'(idx_a), k / 4);
      check($sformatf("auto_upd_%0d", k), 32'(upd_a), (k % 4 == 0) ? 1 : 0);
      check($sformatf("auto_div_%0d", k), 32'(div_a), TABLE[k / 4]);
      check($sformatf("auto_ten_%0d", k), 32'(ten_a), 1);
    end
    start = 1'b0; mode = 1'b1;
    step();
    check("done_pulse", 32'(done_a), 1);
    check("done_ten", 32'(ten_a), 0);
    check("loop_wrap_idx", 32'(idx_b), 0);
    check("loop_wrap_div", 32'(div_b), 47800);
    check("loop_wrap_upd", 32'(upd_b), 1);
    check("loop_wrap_ten", 32'(ten_b), 1);
    step();
    check("done_clear", 32'(done_a), 0);
    check("after_done_busy", 32'(busy_a), 0);
    check("after_done_div", 32'(div_a), 23899);
    check("after_done_idx", 32'(idx_a), 7);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_busy", 32'(busy_b), 0);
    check("loop_no_done", 32'(loop_done_seen), 0);

    // stop at note 3
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    check("n3_idx", 32'(idx_a), 3);
    check("n3_div", 32'(div_a), 35815);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("astop_busy", 32'(busy_a), 0);
    check("astop_ten", 32'(ten_a), 0);
    check("astop_done", 32'(done_a), 0);
    repeat (2) step();
    check("astop_done_later", 32'(done_a), 0);

    // asynchronous reset mid-auto
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    #2;
    reset = 1'b0;
    #1;
    check("arst_div", 32'(div_a), 0);
    check("arst_idx", 32'(idx_a), 0);
    check("arst_ten", 32'(ten_a), 0);
    check("arst_busy", 32'(busy_a), 0);
    check("arst_upd", 32'(upd_a), 0);
    step();
    reset = 1'b1;
    step();
    check("arst_idle", 32'(busy_a), 0);
    start = 1'b1; mode = 1'b0; note_sel = 3'd5;
    step();
    start = 1'b0;
    check("rman_div", 32'(div_a), 28408);
    check("rman_idx", 32'(idx_a), 5);
    check("rman_upd", 32'(upd_a), 1);
    check("rman_ten", 32'(ten_a), 1);
    check("rman_busy", 32'(busy_a), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter N, default 32: width of the divider count output.
REQ-002 Parameter CLK_HZ, default 50_000_000: inclk frequency in Hz.
REQ-003 Parameter NOTE_TICKS, default 25_000_000: inclk cycles each note is held in auto mode; must be >= 2.
REQ-004 Parameter LOOP, default 0: 1 = auto sequence wraps forever; 0 = auto sequence plays once.
REQ-005 inclk  input  1: sole clock; all state updates on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 start  input  1: level sampled each cycle; start request.
REQ-008 stop  input  1: level sampled each cycle; stop request.
REQ-009 mode  input  1: 0 = manual, 1 = auto; sampled only when start is accepted.
REQ-010 note_sel  input  3: manual note index, 0 = C5 ... 7 = C6.
REQ-011 div_clk_count  output  N: half-period count for the downstream clock divider.
REQ-012 tone_en  output  1: high while a tone must sound; drives the divider reset/enable.
REQ-013 note_idx  output  3: index of the note currently loaded.
REQ-014 update  output  1: one-cycle pulse when div_clk_count takes a new value.
REQ-015 busy  output  1: high in any state other than IDLE.
REQ-016 done  output  1: one-cycle pulse when a non-looping auto sequence completes.

Function
REQ-017 FSM states SHALL be IDLE, MANUAL, AUTO_HOLD, and DONE.
REQ-018 Note table (count = CLK_HZ/(2*f) truncated, minus 1, at 50 MHz) SHALL be: 0:47800 1:42588 2:37935 3:35815 4:31927 5:28408 6:25328 7:23899.
REQ-019 In IDLE, start=1 with stop=0 and mode=0 SHALL go to MANUAL; note_idx<=note_sel; div_clk_count<=table[note_sel]; update=1 and tone_en=1 from the next cycle.
REQ-020 In IDLE, start=1 with stop=0 and mode=1 SHALL go to AUTO_HOLD; note_idx<=0; div_clk_count<=47800; tick counter<=0; update pulses.
REQ-021 In MANUAL, when note_sel differs from note_idx, note_idx and div_clk_count SHALL update on the next edge with an update pulse; 1-cycle latency; no pulse when note_sel is unchanged.
REQ-022 In AUTO_HOLD, the tick counter SHALL increment each cycle; at count NOTE_TICKS-1 it clears and note_idx advances by 1 with a table reload and an update pulse, so each note lasts exactly NOTE_TICKS cycles.
REQ-023 At expiry of note 7: if LOOP=1, wrap to index 0 and continue; if LOOP=0, go to DONE with tone_en=0.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 stop=1 in MANUAL or AUTO_HOLD SHALL go to IDLE on the next edge; tone_en=0; no done pulse.
REQ-026 When start and stop are both high, stop SHALL win: remain in or return to IDLE.
REQ-027 start while busy SHALL be ignored, and mode changes while busy SHALL be ignored.
REQ-028 tone_en SHALL equal 1 exactly in MANUAL and AUTO_HOLD.
REQ-029 div_clk_count SHALL hold its last value in IDLE and DONE.
REQ-030 Table values SHALL be zero-extended to N bits; the tick counter width SHALL be $clog2(NOTE_TICKS).

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE, div_clk_count=0, note_idx=0, tick counter=0, and tone_en, update, busy, done all 0.
REQ-032 Reset asserted mid-sequence SHALL abort immediately; after release the block waits for a new start.

Structure
REQ-033 Package tone_pkg SHALL hold the FSM state enum, the NOTE_COUNT=8 constant, and the note frequency constants.
REQ-034 Sub-module note_lut SHALL be purely combinational: 3-bit index in, N-bit count out, computed from CLK_HZ.
REQ-035 Outputs SHALL be registered, except busy and tone_en, which may decode state directly.

Verification (NOTE_TICKS=4 unless noted)
REQ-036 Reset release, then start with mode=0 and note_sel=5 -> next cycle: div_clk_count=28408, note_idx=5, update=1, tone_en=1, busy=1.
REQ-037 In MANUAL, change note_sel 5->2 -> one cycle later: div_clk_count=37935 with a single update pulse; hold note_sel=2 for 10 cycles -> no further update pulses.
REQ-038 Auto mode, LOOP=0 -> update pulses every 4 cycles, note_idx 0..7, 32 cycles total; then done=1 for one cycle, tone_en=0, busy=0.
REQ-039 Auto mode, LOOP=1 -> after index 7, note_idx=0 and div_clk_count=47800; done never asserts.
REQ-040 start and stop high together from IDLE -> remains in IDLE; stop during auto at note 3 -> IDLE next cycle, tone_en=0, done=0.
REQ-041 Assert reset asynchronously mid-AUTO_HOLD, between clock edges -> outputs zero immediately; after release, a start in manual mode behaves as in REQ-036.
